// File: rtl/xge_sync_pkg.sv
// Shared types and defaults for the MAC status event synchronizer.
// Imported by the toggle synchronizer channel and the Wishbone-side top.
package xge_sync_pkg;

    typedef enum logic {
        SYNC_INIT,
        SYNC_RUN
    } sync_state_t;

    localparam int XGE_NEVT        = 8;
    localparam int XGE_META_STAGES = 2;
    localparam int XGE_EVT_CNT_W   = 16;

endpackage

// File: rtl/toggle_edge_sync.sv
// One toggle-encoded event channel: metastability chain, previous-level flop
// and a registered edge pulse gated by the top-level enable.
module toggle_edge_sync
    import xge_sync_pkg::*;
#(
    parameter int META_STAGES = XGE_META_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic tog,
    input  logic en,
    output logic pulse
);

    logic [META_STAGES-1:0] chain;
    logic                   prev;
    logic                   sync_last;

    assign sync_last = chain[META_STAGES-1];

    // Chain and prev keep loading while disabled so the first enabled
    // compare sees a settled level, not the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            chain <= {chain[META_STAGES-2:0], tog};
            prev  <= sync_last;
            pulse <= en & (sync_last ^ prev);
        end
    end

endmodule

// File: rtl/status_event_sync_wb.sv
// Wishbone-side receiver for toggle-encoded MAC status events: pulses,
// sticky pending/overflow bits, saturating counters with read-and-clear.
module status_event_sync_wb
    import xge_sync_pkg::*;
#(
    parameter int NEVT        = XGE_NEVT,
    parameter int META_STAGES = XGE_META_STAGES,
    parameter int CNT_W       = XGE_EVT_CNT_W,
    localparam int SEL_W      = (NEVT > 1) ? $clog2(NEVT) : 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NEVT-1:0]  evt_toggle_i,
    input  logic [NEVT-1:0]  int_mask_i,
    input  logic [NEVT-1:0]  pend_clr_i,
    input  logic             cnt_rd_i,
    input  logic [SEL_W-1:0] cnt_sel_i,
    output logic [NEVT-1:0]  evt_pulse_o,
    output logic [NEVT-1:0]  pend_o,
    output logic [NEVT-1:0]  ovf_o,
    output logic [CNT_W-1:0] cnt_data_o,
    output logic             cnt_valid_o,
    output logic             int_o
);

    localparam int INIT_W = $clog2(META_STAGES + 1);

    sync_state_t       state, state_nx;
    logic [INIT_W-1:0] init_cnt, init_cnt_nx;
    logic              sync_en;

    logic [CNT_W-1:0]  cnt_q [NEVT];
    logic [NEVT-1:0]   rd_hit;
    logic [CNT_W-1:0]  rd_data;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= SYNC_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
        end
    end

    // Pulses stay masked until the chains have flushed their reset state.
    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        sync_en     = 1'b0;
        unique case (state)
            SYNC_INIT: begin
                if (init_cnt == INIT_W'(META_STAGES))
                    state_nx = SYNC_RUN;
                else
                    init_cnt_nx = init_cnt + INIT_W'(1);
            end
            SYNC_RUN: begin
                sync_en = 1'b1;
            end
            default: begin
                state_nx = SYNC_INIT;
            end
        endcase
    end

    for (genvar g = 0; g < NEVT; g++) begin : g_sync
        toggle_edge_sync #(
            .META_STAGES(META_STAGES)
        ) u_sync (
            .clk  (wb_clk_i),
            .rst  (wb_rst_i),
            .tog  (evt_toggle_i[g]),
            .en   (sync_en),
            .pulse(evt_pulse_o[g])
        );
    end

    always_comb begin
        rd_hit  = '0;
        rd_data = '0;
        for (int i = 0; i < NEVT; i++) begin
            if (cnt_rd_i && cnt_sel_i == SEL_W'(i)) begin
                rd_hit[i] = 1'b1;
                rd_data   = cnt_q[i];
            end
        end
    end

    // A pulse landing on the cycle of a read is kept as the new count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NEVT; i++)
                cnt_q[i] <= '0;
            ovf_o  <= '0;
            pend_o <= '0;
        end else begin
            for (int i = 0; i < NEVT; i++) begin
                if (rd_hit[i]) begin
                    cnt_q[i] <= evt_pulse_o[i] ? CNT_W'(1) : '0;
                    ovf_o[i] <= evt_pulse_o[i] & (&cnt_q[i]);
                end else if (evt_pulse_o[i]) begin
                    if (&cnt_q[i])
                        ovf_o[i] <= 1'b1;
                    else
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
                pend_o[i] <= evt_pulse_o[i] |
                             (pend_o[i] & ~pend_clr_i[i]);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_data_o  <= '0;
            cnt_valid_o <= 1'b0;
            int_o       <= 1'b0;
        end else begin
            if (cnt_rd_i)
                cnt_data_o <= rd_data;
            cnt_valid_o <= cnt_rd_i;
            int_o       <= |(pend_o & int_mask_i);
        end
    end

endmodule

// File: tb/tb_status_event_sync_wb.sv
// Randomized and directed bench for status_event_sync_wb (NEVT=6, CNT_W=4)
// against an event-level reference model.
module tb_status_event_sync_wb;

    localparam int NEVT  = 6;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int LAT   = 4;

    logic             clk;
    logic             rst;
    logic [NEVT-1:0]  tog;
    logic [NEVT-1:0]  mask;
    logic [NEVT-1:0]  clr;
    logic             rd;
    logic [2:0]       sel;
    logic [NEVT-1:0]  evt_pulse;
    logic [NEVT-1:0]  pend;
    logic [NEVT-1:0]  ovf;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_valid;
    logic             irq;

    status_event_sync_wb #(
        .NEVT(NEVT),
        .META_STAGES(2),
        .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .evt_toggle_i(tog),
        .int_mask_i  (mask),
        .pend_clr_i  (clr),
        .cnt_rd_i    (rd),
        .cnt_sel_i   (sel),
        .evt_pulse_o (evt_pulse),
        .pend_o      (pend),
        .ovf_o       (ovf),
        .cnt_data_o  (cnt_data),
        .cnt_valid_o (cnt_valid),
        .int_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // model state: edges since reset release, sampled input history
    int              m_cyc;
    logic [NEVT-1:0] s_hist [4];
    logic [NEVT-1:0] m_pulse;
    logic [NEVT-1:0] m_pend;
    logic [NEVT-1:0] m_ovf;
    int              m_cnt [NEVT];
    logic            m_int;
    logic            m_valid;
    int              m_data;
    int              last_tog [NEVT];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        for (int j = 0; j < 4; j++) s_hist[j] = '0;
        m_pulse = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_int   = 1'b0;
        m_valid = 1'b0;
        m_data  = 0;
        for (int i = 0; i < NEVT; i++) begin
            m_cnt[i]    = 0;
            last_tog[i] = -100;
        end
    endtask

    // An input level sampled at edge c shows up as a pulse after edge c+2,
    // and pulses before edge LAT after reset release are discarded.
    task automatic model_edge();
        logic [NEVT-1:0] np;
        m_cyc++;
        for (int j = 3; j > 0; j--) s_hist[j] = s_hist[j-1];
        s_hist[0] = tog;
        np = (m_cyc >= LAT) ? (s_hist[2] ^ s_hist[3]) : '0;
        m_int   = |(m_pend & mask);
        m_valid = rd;
        if (rd) m_data = (sel < NEVT) ? m_cnt[sel] : 0;
        for (int i = 0; i < NEVT; i++) begin
            if (rd && sel == i) begin
                m_ovf[i] = m_pulse[i] && (m_cnt[i] == CMAX);
                m_cnt[i] = m_pulse[i] ? 1 : 0;
            end else if (m_pulse[i]) begin
                if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end
            m_pend[i] = m_pulse[i] | (m_pend[i] & ~clr[i]);
        end
        m_pulse = np;
    endtask

    task automatic check_all();
        chk("evt_pulse", 32'(evt_pulse), 32'(m_pulse));
        chk("pend", 32'(pend), 32'(m_pend));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("int", 32'(irq), 32'(m_int));
        chk("cnt_valid", 32'(cnt_valid), 32'(m_valid));
        chk("cnt_data", 32'(cnt_data), 32'(m_data));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic toggle_ch(input int ch);
        tog[ch] = ~tog[ch];
        last_tog[ch] = m_cyc;
    endtask

    task automatic read_ch(input int ch);
        rd  = 1'b1;
        sel = 3'(ch);
        tick();
        rd  = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        tog  = '0;
        mask = '0;
        clr  = '0;
        rd   = 1'b0;
        sel  = '0;
        rst  = 1'b0;
        model_reset();
        do_reset();
        ticks(6);

        // single event on ch2 with its interrupt enabled
        mask = 6'b000100;
        toggle_ch(2);
        ticks(3);
        chk("ch2_pulse", 32'(evt_pulse[2]), 32'd1);
        tick();
        chk("ch2_pend", 32'(pend[2]), 32'd1);
        chk("ch2_pulse_gone", 32'(evt_pulse[2]), 32'd0);
        tick();
        chk("ch2_int", 32'(irq), 32'd1);
        read_ch(2);
        chk("ch2_cnt", 32'(cnt_data), 32'd1);
        chk("ch2_valid", 32'(cnt_valid), 32'd1);

        // all inputs high across reset release
        mask = '0;
        tog  = '1;
        do_reset();
        ticks(8);
        chk("ff_pend", 32'(pend), 32'd0);
        read_ch(0);
        chk("ff_cnt0", 32'(cnt_data), 32'd0);

        // five spaced events on ch0, then read twice back to back
        for (int n = 0; n < 5; n++) begin
            toggle_ch(0);
            ticks(4);
        end
        rd  = 1'b1;
        sel = 3'd0;
        tick();
        chk("ch0_cnt5", 32'(cnt_data), 32'd5);
        chk("ch0_valid", 32'(cnt_valid), 32'd1);
        tick();
        rd = 1'b0;
        chk("ch0_reread", 32'(cnt_data), 32'd0);

        // saturate ch1
        for (int n = 0; n < 17; n++) begin
            toggle_ch(1);
            ticks(4);
        end
        chk("ch1_ovf", 32'(ovf[1]), 32'd1);
        read_ch(1);
        chk("ch1_sat", 32'(cnt_data), 32'(CMAX));
        chk("ch1_ovf_clr", 32'(ovf[1]), 32'd0);

        // pulse on ch3 coincident with clear and read
        for (int n = 0; n < 7; n++) begin
            toggle_ch(3);
            ticks(4);
        end
        toggle_ch(3);
        ticks(3);
        clr = 6'b001000;
        rd  = 1'b1;
        sel = 3'd3;
        tick();
        clr = '0;
        chk("ch3_pend_set_wins", 32'(pend[3]), 32'd1);
        chk("ch3_cnt7", 32'(cnt_data), 32'd7);
        tick();
        rd = 1'b0;
        chk("ch3_cnt_after", 32'(cnt_data), 32'd1);

        // out-of-range selects
        for (int s = 6; s < 8; s++) begin
            read_ch(s);
            chk("oor_data", 32'(cnt_data), 32'd0);
            chk("oor_valid", 32'(cnt_valid), 32'd1);
        end
        read_ch(2);
        chk("ch2_kept", 32'(cnt_data), 32'(m_data));

        // randomized traffic with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                tog = NEVT'($urandom);
                do_reset();
            end
            for (int i = 0; i < NEVT; i++)
                if ((m_cyc - last_tog[i]) >= LAT &&
                    $urandom_range(0, 5) == 0)
                    toggle_ch(i);
            mask = NEVT'($urandom);
            clr  = ($urandom_range(0, 7) == 0) ? NEVT'($urandom) : '0;
            rd   = ($urandom_range(0, 3) == 0);
            sel  = 3'($urandom_range(0, 7));
            tick();
        end
        rd  = 1'b0;
        clr = '0;
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
